// File: rtl/timer_ctrl_master_if.sv
// Avalon-MM link between timer_ctrl_master and the 16-bit interval timer slave.
//   avm_address    3   word address (initiator -> slave)
//   avm_chipselect 1   access strobe, one cycle per access
//   avm_write_n    1   0 = write, 1 = read
//   avm_writedata  16  write data
//   avm_readdata   16  read data, registered one cycle after the address
//   timer_irq      1   level interrupt from the timer, cleared by a status write
interface timer_ctrl_master_if;
    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata;
    logic        timer_irq;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_write_n,
        output avm_writedata,
        input  avm_readdata,
        input  timer_irq
    );

    modport slave (
        input  avm_address,
        input  avm_chipselect,
        input  avm_write_n,
        input  avm_writedata,
        output avm_readdata,
        output timer_irq
    );
endinterface

// File: rtl/timer_ctrl_master.sv
// Hardware sequencer for the interval timer: programs the period, starts the
// timer, services each timeout (status clear + tick pulse), optionally stops
// after a number of timeouts, and reads back a snapshot of the live counter.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   cmd_start             start pulse, accepted only while idle
//   cmd_period[31:0]      timer period, sampled with cmd_start
//   cmd_continuous        1 = auto-reload, sampled with cmd_start
//   cmd_count[CNT_W-1:0]  timeouts before auto-stop (0 = until cmd_stop)
//   cmd_stop              abort pulse
//   snap_req              counter snapshot request pulse
//   busy                  run in progress
//   tick                  one pulse per serviced timeout
//   tick_count            timeouts serviced this run (saturating)
//   done                  one pulse on return to idle
//   snap_valid/snap_value snapshot result {high,low}
//   avm                   timer bus, master side
//
// state    | meaning
// IDLE     | no run; waiting for cmd_start
// WR_PL    | write period low half   (addr 2)
// WR_PH    | write period high half  (addr 3)
// WR_CTRL  | write control: start, ito, cont (addr 1)
// WAIT_IRQ | bus idle; arbitrate stop > irq > snapshot
// CLR_ST   | clear status (addr 0) and tick
// SNAP_WR  | write snap register to latch counter (addr 4)
// RD_L     | read snapshot low  (addr 4)
// RD_H     | read snapshot high (addr 5); low data returns now
// SNAP_FIN | bus idle; high data returns now
// WR_STOP  | write control stop (addr 1, 0x8)
module timer_ctrl_master #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_start,
    input  logic [31:0]      cmd_period,
    input  logic             cmd_continuous,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_stop,
    input  logic             snap_req,
    output logic             busy,
    output logic             tick,
    output logic [CNT_W-1:0] tick_count,
    output logic             done,
    output logic             snap_valid,
    output logic [31:0]      snap_value,
    timer_ctrl_master_if.master avm
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTRL,
        ST_WAIT_IRQ,
        ST_CLR_ST,
        ST_SNAP_WR,
        ST_RD_L,
        ST_RD_H,
        ST_SNAP_FIN,
        ST_WR_STOP
    } state_t;

    localparam logic [2:0]       ADDR_STATUS  = 3'd0;
    localparam logic [2:0]       ADDR_CONTROL = 3'd1;
    localparam logic [2:0]       ADDR_PERIODL = 3'd2;
    localparam logic [2:0]       ADDR_PERIODH = 3'd3;
    localparam logic [2:0]       ADDR_SNAPL   = 3'd4;
    localparam logic [2:0]       ADDR_SNAPH   = 3'd5;
    localparam logic [15:0]      CTRL_STOP    = 16'h0008;
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    state_t           state, state_nxt;
    logic [31:0]      period, period_nxt;
    logic             cont, cont_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             stop_pend, stop_pend_nxt;
    logic             snap_pend, snap_pend_nxt;
    logic             stop_now, snap_now;

    logic             busy_nxt, tick_nxt, done_nxt, snap_valid_nxt;
    logic [CNT_W-1:0] tick_count_nxt;
    logic [31:0]      snap_value_nxt;

    logic [2:0]       address_nxt;
    logic             chipselect_nxt, write_n_nxt;
    logic [15:0]      writedata_nxt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state              <= ST_IDLE;
            period             <= '0;
            cont               <= 1'b0;
            count              <= '0;
            stop_pend          <= 1'b0;
            snap_pend          <= 1'b0;
            busy               <= 1'b0;
            tick               <= 1'b0;
            done               <= 1'b0;
            snap_valid         <= 1'b0;
            tick_count         <= '0;
            snap_value         <= '0;
            avm.avm_address    <= '0;
            avm.avm_chipselect <= 1'b0;
            avm.avm_write_n    <= 1'b1;
            avm.avm_writedata  <= '0;
        end else begin
            state              <= state_nxt;
            period             <= period_nxt;
            cont               <= cont_nxt;
            count              <= count_nxt;
            stop_pend          <= stop_pend_nxt;
            snap_pend          <= snap_pend_nxt;
            busy               <= busy_nxt;
            tick               <= tick_nxt;
            done               <= done_nxt;
            snap_valid         <= snap_valid_nxt;
            tick_count         <= tick_count_nxt;
            snap_value         <= snap_value_nxt;
            avm.avm_address    <= address_nxt;
            avm.avm_chipselect <= chipselect_nxt;
            avm.avm_write_n    <= write_n_nxt;
            avm.avm_writedata  <= writedata_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        period_nxt     = period;
        cont_nxt       = cont;
        count_nxt      = count;
        stop_pend_nxt  = stop_pend;
        snap_pend_nxt  = snap_pend;
        busy_nxt       = busy;
        tick_nxt       = 1'b0;
        done_nxt       = 1'b0;
        snap_valid_nxt = 1'b0;
        tick_count_nxt = tick_count;
        snap_value_nxt = snap_value;
        address_nxt    = '0;
        chipselect_nxt = 1'b0;
        write_n_nxt    = 1'b1;
        writedata_nxt  = '0;

        stop_now = cmd_stop | stop_pend;
        snap_now = snap_req | snap_pend;

        case (state)
            ST_IDLE: begin
                if (cmd_start) begin
                    state_nxt      = ST_WR_PL;
                    period_nxt     = cmd_period;
                    cont_nxt       = cmd_continuous;
                    count_nxt      = cmd_count;
                    tick_count_nxt = '0;
                    busy_nxt       = 1'b1;
                end
            end
            ST_WR_PL:   state_nxt = ST_WR_PH;
            ST_WR_PH:   state_nxt = ST_WR_CTRL;
            ST_WR_CTRL: state_nxt = ST_WAIT_IRQ;
            ST_WAIT_IRQ: begin
                if (stop_now)
                    state_nxt = ST_WR_STOP;
                else if (avm.timer_irq)
                    state_nxt = ST_CLR_ST;
                else if (snap_now)
                    state_nxt = ST_SNAP_WR;
            end
            ST_CLR_ST: begin
                // tick_count already holds the incremented value here
                if ((count != '0) && (tick_count == count))
                    state_nxt = ST_WR_STOP;
                else if (!cont)
                    state_nxt = ST_WR_CTRL;
                else
                    state_nxt = ST_WAIT_IRQ;
            end
            ST_SNAP_WR: state_nxt = ST_RD_L;
            ST_RD_L:    state_nxt = ST_RD_H;
            ST_RD_H: begin
                snap_value_nxt[15:0] = avm.avm_readdata;
                state_nxt            = ST_SNAP_FIN;
            end
            ST_SNAP_FIN: begin
                snap_value_nxt[31:16] = avm.avm_readdata;
                snap_valid_nxt        = 1'b1;
                state_nxt             = ST_WAIT_IRQ;
            end
            ST_WR_STOP: begin
                state_nxt = ST_IDLE;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Requests seen outside WAIT_IRQ are held until they can be honoured;
        // nothing survives a return to idle.
        if (state == ST_IDLE) begin
            stop_pend_nxt = 1'b0;
            snap_pend_nxt = 1'b0;
        end else begin
            if (state_nxt == ST_WR_STOP)
                stop_pend_nxt = 1'b0;
            else if (cmd_stop)
                stop_pend_nxt = 1'b1;
            if (state_nxt == ST_SNAP_WR)
                snap_pend_nxt = 1'b0;
            else if (snap_req)
                snap_pend_nxt = 1'b1;
        end

        if (state_nxt == ST_CLR_ST) begin
            tick_nxt       = 1'b1;
            tick_count_nxt = (tick_count == CNT_MAX) ? tick_count : tick_count + CNT_W'(1);
        end

        // Bus outputs are registered, so they are decoded from the state being
        // entered; each bus state then shows its access for exactly one cycle.
        case (state_nxt)
            ST_WR_PL: begin
                chipselect_nxt = 1'b1;
                write_n_nxt    = 1'b0;
                address_nxt    = ADDR_PERIODL;
                writedata_nxt  = period_nxt[15:0];
            end
            ST_WR_PH: begin
                chipselect_nxt = 1'b1;
                write_n_nxt    = 1'b0;
                address_nxt    = ADDR_PERIODH;
                writedata_nxt  = period_nxt[31:16];
            end
            ST_WR_CTRL: begin
                chipselect_nxt = 1'b1;
                write_n_nxt    = 1'b0;
                address_nxt    = ADDR_CONTROL;
                // {stop, start, cont, ito}
                writedata_nxt  = {12'h000, 1'b0, 1'b1, cont_nxt, 1'b1};
            end
            ST_CLR_ST: begin
                chipselect_nxt = 1'b1;
                write_n_nxt    = 1'b0;
                address_nxt    = ADDR_STATUS;
            end
            ST_SNAP_WR: begin
                chipselect_nxt = 1'b1;
                write_n_nxt    = 1'b0;
                address_nxt    = ADDR_SNAPL;
            end
            ST_RD_L: begin
                chipselect_nxt = 1'b1;
                address_nxt    = ADDR_SNAPL;
            end
            ST_RD_H: begin
                chipselect_nxt = 1'b1;
                address_nxt    = ADDR_SNAPH;
            end
            ST_WR_STOP: begin
                chipselect_nxt = 1'b1;
                write_n_nxt    = 1'b0;
                address_nxt    = ADDR_CONTROL;
                writedata_nxt  = CTRL_STOP;
            end
            default: begin
                chipselect_nxt = 1'b0;
                write_n_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/timer_ctrl_master.md
Name: timer_ctrl_master

Overview:
- Avalon-MM initiator that programs, services and reads back the 16-bit-data-bus interval timer slave (6 word registers, 3-bit address).
- Loads a 32-bit period, starts the timer, and waits on the timer IRQ. On each timeout it clears the status and emits one tick pulse.
- Optionally stops after N timeouts. On request it snapshots the live counter and returns it as a 32-bit value.
- Sits between fabric control logic (vision pipeline frame pacing) and the timer slave, so no CPU is needed to drive the timer.

Parameters:
- CNT_W, 16, width of timeout count request and tick counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low
- cmd_start  in  1  one-cycle pulse; accepted only when busy=0
- cmd_period  in  32  timer period value (timer counts period..0); sampled with cmd_start
- cmd_continuous  in  1  1 = timer auto-reloads; sampled with cmd_start
- cmd_count  in  CNT_W  timeouts before auto-stop; 0 = run until cmd_stop; sampled with cmd_start
- cmd_stop  in  1  pulse; abort run
- snap_req  in  1  pulse; request counter snapshot
- busy  out  1  high from cmd_start acceptance until return to IDLE
- tick  out  1  one-cycle pulse per serviced timeout
- tick_count  out  CNT_W  timeouts serviced this run
- done  out  1  one-cycle pulse on return to IDLE
- snap_valid  out  1  one-cycle pulse; snap_value valid
- snap_value  out  32  captured counter {high,low}
- avm_address  out  3  slave word address
- avm_chipselect  out  1  bus access strobe
- avm_write_n  out  1  active-low write
- avm_writedata  out  16  write data
- avm_readdata  in  16  slave read data, fixed latency 1 (registered from the address presented the previous cycle)
- timer_irq  in  1  level IRQ from timer

Behaviour:
- Reset (synchronous, reset_n=0 at clk edge): state IDLE; busy=0, tick=0, done=0, snap_valid=0, tick_count=0, snap_value=0, avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0. Reset mid-run abandons the bus op; no stop write is issued.
- All bus outputs are registered. Each bus state lasts exactly one cycle with chipselect=1. Writes use write_n=0; reads use write_n=1. The slave has no waitrequest.
- FSM:
  - IDLE: on cmd_start, latch cmd_* into shadow regs, tick_count<=0, busy<=1 -> WR_PL.
  - WR_PL: addr 2, data period[15:0] -> WR_PH.
  - WR_PH: addr 3, data period[31:16] -> WR_CTRL.
  - WR_CTRL: addr 1, data {stop=0, start=1, cont=continuous, ito=1} (0x7 or 0x5) -> WAIT_IRQ.
  - WAIT_IRQ: bus idle. Priority: cmd_stop -> WR_STOP; else timer_irq -> CLR_ST; else snap_req -> SNAP_WR.
  - CLR_ST: addr 0, data 0. Same cycle: tick<=1, tick_count+1 (saturating at all-ones). Next state: if cmd_count!=0 and new tick_count==cmd_count -> WR_STOP; else if continuous=0 -> WR_CTRL (restart); else -> WAIT_IRQ.
  - SNAP_WR: addr 4, data 0 -> RD_L.
  - RD_L: addr 4 read -> RD_H.
  - RD_H: addr 5 read; capture avm_readdata into snap_value[15:0] -> SNAP_FIN.
  - SNAP_FIN: bus idle; capture avm_readdata into snap_value[31:16]; snap_valid<=1 -> WAIT_IRQ.
  - WR_STOP: addr 1, data 0x8 (stop, ito=0) -> IDLE; done<=1, busy<=0 registered on entry to IDLE.
- cmd_stop outside WAIT_IRQ is latched as pending and honoured at the next WAIT_IRQ, ahead of irq and snap_req. A snap_req arriving outside WAIT_IRQ is latched the same way. Duplicate requests collapse into one.
- IRQ and stop together in WAIT_IRQ: stop wins; the timeout is not ticked.
- IRQ asserted during a snapshot sequence is serviced on return to WAIT_IRQ. The level persists until CLR_ST.
- cmd_start while busy is ignored.
- Required: cmd_period >= 8 so that a timeout cannot coincide with the CLR_ST write. Behaviour below 8 is unspecified.
- cmd_period = 0 is legal for programming only; it is not guaranteed to tick.

Test Plan:
- Reset then idle: hold reset_n=0 3 cycles -> all outputs at reset values; chipselect never high.
- Program, 3 ticks, continuous: cmd_start, period=0x0001_0010, cont=1, count=3 -> writes (2,0x0010), (3,0x0001), (1,0x0007) on consecutive cycles. Each irq yields write (0,0) plus tick. After the 3rd tick: write (1,0x0008), done pulse, tick_count=3, busy=0.
- One-shot restart: cont=0, count=2, period=20 -> after the first CLR_ST, the next bus cycle is (1,0x0005). Exactly 2 ticks, then stop write.
- Snapshot: with the slave model counter at 0x0002_ABCD at the SNAP_WR edge -> bus sequence write(4), read(4), read(5). snap_valid fires 3 cycles after SNAP_WR with snap_value=0x0002_ABCD.
- Abort and collisions: cmd_stop during RD_L -> snapshot completes, then WR_STOP, done. Stop and irq in the same WAIT_IRQ cycle -> no tick, (1,0x0008) issued.
- Reset mid-run: reset_n=0 during WR_PH -> next cycle IDLE, chipselect=0, no further writes. A new cmd_start is accepted afterwards.
